// File: rtl/core_exu_lsu_pkg.sv
// Shared LSU definitions: RV32I load/store funct3 codes, FSM states and legality helpers.
// Pure declarations; no logic, no latency, no flow control.
package core_exu_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // funct3[1:0] encodes the access width for both loads and stores
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_LB, F3_LH, F3_LW: ok = 1'b1;
      F3_LBU, F3_LHU:      ok = !is_store;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    case (f3[1:0])
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/core_exu_lsu_fmt.sv
// Store lane replication/strobes and load byte/halfword extract with sign/zero extension.
// Purely combinational, zero latency; no flow control.
module core_exu_lsu_fmt
  import core_exu_lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_wstrb = 4'b1111;
    o_wdata = i_wdata;
    case (i_funct3[1:0])
      SZ_BYTE: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_wstrb = 4'b0011 << i_addr_lo;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    o_rdata = '0;
    case (i_funct3)
      F3_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_rdata = {{16{w_half[15]}}, w_half};
      F3_LW:   o_rdata = i_rdata;
      F3_LBU:  o_rdata = {24'd0, w_byte};
      F3_LHU:  o_rdata = {16'd0, w_half};
      default: o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/core_exu_lsu.sv
// EXU load/store unit: single-outstanding dmem request with timeout; done T+3 at zero-wait memory, T+1 on local fault.
// Accepts work only in IDLE; request fields hold steady until dmem_req_ready.
module core_exu_lsu
  import core_exu_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lsu_req_valid,
  output logic        o_lsu_req_ready,
  input  logic        i_lsu_is_store,
  input  logic [2:0]  i_lsu_funct3,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  output logic        o_lsu_done,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_misalign,
  output logic        o_lsu_err,
  output logic        o_dmem_req_valid,
  input  logic        i_dmem_req_ready,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_wstrb,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_rsp_valid,
  input  logic [31:0] i_dmem_rsp_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_e    r_state, w_next;
  logic [31:0]   r_addr, r_wdata, r_rdata;
  logic [2:0]    r_funct3;
  logic          r_is_store, r_misalign, r_err;
  logic [CW-1:0] r_cnt;

  logic          w_legal, w_misalign, w_timeout, w_in_req, w_in_resp;
  logic [3:0]    w_wstrb;
  logic [31:0]   w_wdata, w_rdata;

  assign w_legal    = f3_legal(i_lsu_is_store, i_lsu_funct3);
  assign w_misalign = f3_misaligned(i_lsu_funct3, i_lsu_addr[1:0]);
  // Last WAIT cycle: the counter would reach TIMEOUT on this edge
  assign w_timeout  = (r_cnt == CW'(TIMEOUT - 1));
  assign w_in_req   = (r_state == ST_REQ);
  assign w_in_resp  = (r_state == ST_RESP);

  core_exu_lsu_fmt u_fmt (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_rdata   (i_dmem_rsp_rdata),
    .o_wstrb   (w_wstrb),
    .o_wdata   (w_wdata),
    .o_rdata   (w_rdata)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_lsu_req_valid) w_next = (!w_legal || w_misalign) ? ST_RESP : ST_REQ;
      ST_REQ:  if (i_dmem_req_ready) w_next = ST_WAIT;
      ST_WAIT: if (i_dmem_rsp_valid || w_timeout) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_funct3   <= '0;
      r_is_store <= 1'b0;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (i_lsu_req_valid) begin
          r_addr     <= i_lsu_addr;
          r_wdata    <= i_lsu_wdata;
          r_funct3   <= i_lsu_funct3;
          r_is_store <= i_lsu_is_store;
          r_rdata    <= '0;
          r_err      <= !w_legal;
          r_misalign <= w_legal && w_misalign;
        end
        ST_REQ: if (i_dmem_req_ready) r_cnt <= '0;
        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (i_dmem_rsp_valid) r_rdata <= r_is_store ? '0 : w_rdata;
          else if (w_timeout) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_lsu_req_ready  = (r_state == ST_IDLE);
  assign o_lsu_done       = w_in_resp;
  assign o_lsu_rdata      = w_in_resp ? r_rdata : '0;
  assign o_lsu_misalign   = w_in_resp && r_misalign;
  assign o_lsu_err        = w_in_resp && r_err;
  assign o_dmem_req_valid = w_in_req;
  assign o_dmem_we        = w_in_req && r_is_store;
  assign o_dmem_addr      = w_in_req ? {r_addr[31:2], 2'b00} : '0;
  assign o_dmem_wstrb     = (w_in_req && r_is_store) ? w_wstrb : 4'b0000;
  assign o_dmem_wdata     = (w_in_req && r_is_store) ? w_wdata : '0;

endmodule

// File: tb/tb_core_exu_lsu.sv
// Self-checking bench for core_exu_lsu: directed vector table, reset-in-flight sequence, random traffic vs reference model.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_core_exu_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, is_store;
  logic [2:0]  f3;
  logic [31:0] addr, wdata, rdata;
  logic        done, mis, err;
  logic        dv, dr, dwe, rv;
  logic [31:0] daddr, dwdata, rrd;
  logic [3:0]  dwstrb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  core_exu_lsu #(.TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_lsu_req_valid(req_valid), .o_lsu_req_ready(req_ready),
    .i_lsu_is_store(is_store), .i_lsu_funct3(f3), .i_lsu_addr(addr), .i_lsu_wdata(wdata),
    .o_lsu_done(done), .o_lsu_rdata(rdata), .o_lsu_misalign(mis), .o_lsu_err(err),
    .o_dmem_req_valid(dv), .i_dmem_req_ready(dr), .o_dmem_we(dwe), .o_dmem_addr(daddr),
    .o_dmem_wstrb(dwstrb), .o_dmem_wdata(dwdata),
    .i_dmem_rsp_valid(rv), .i_dmem_rsp_rdata(rrd)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rd;
    int          rsp;
    logic [31:0] mrd;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_mis;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    int          e_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic st, input logic [2:0] fn, input logic [31:0] a,
                               input logic [31:0] wd, input int rd, input int rsp,
                               input logic [31:0] mrd, input logic [31:0] er, input logic ee,
                               input logic em, input logic [3:0] ews, input logic [31:0] ewd,
                               input int lat);
    vec_t v;
    v.st = st; v.f3 = fn; v.addr = a; v.wdata = wd; v.rd = rd; v.rsp = rsp; v.mrd = mrd;
    v.e_rdata = er; v.e_err = ee; v.e_mis = em; v.e_wstrb = ews; v.e_wdata = ewd; v.e_lat = lat;
    return v;
  endfunction

  // Reference model: expectations from the ISA rules using plain arithmetic
  function automatic vec_t model(input vec_t v);
    vec_t o = v;
    int size, off;
    logic legal;
    logic [31:0] bv, hv;
    off = int'(v.addr % 4);
    if (v.st) legal = (v.f3 == 0 || v.f3 == 1 || v.f3 == 2);
    else      legal = (v.f3 == 0 || v.f3 == 1 || v.f3 == 2 || v.f3 == 4 || v.f3 == 5);
    size = (v.f3 == 0 || v.f3 == 4) ? 1 : (v.f3 == 1 || v.f3 == 5) ? 2 : 4;
    o.e_rdata = 0; o.e_err = 0; o.e_mis = 0; o.e_wstrb = 0; o.e_wdata = 0;
    if (!legal) begin
      o.e_err = 1; o.e_lat = 1;
    end else if (off % size != 0) begin
      o.e_mis = 1; o.e_lat = 1;
    end else begin
      if (v.st) begin
        if (size == 1)      begin o.e_wstrb = 4'(1 << off); o.e_wdata = (v.wdata & 32'hFF) * 32'h01010101; end
        else if (size == 2) begin o.e_wstrb = 4'(3 << off); o.e_wdata = (v.wdata & 32'hFFFF) * 32'h00010001; end
        else                begin o.e_wstrb = 4'hF; o.e_wdata = v.wdata; end
      end
      if (v.rsp >= TO) begin
        o.e_err = 1; o.e_lat = 2 + v.rd + TO;
      end else begin
        o.e_lat = 3 + v.rd + v.rsp;
        bv = (v.mrd >> (8 * off)) & 32'hFF;
        hv = (v.mrd >> (16 * (off / 2))) & 32'hFFFF;
        if (!v.st) begin
          case (v.f3)
            0: o.e_rdata = (bv >= 128) ? bv + 32'hFFFFFF00 : bv;
            1: o.e_rdata = (hv >= 32768) ? hv + 32'hFFFF0000 : hv;
            2: o.e_rdata = v.mrd;
            4: o.e_rdata = bv;
            default: o.e_rdata = hv;
          endcase
        end
      end
    end
    return o;
  endfunction

  // Called at a falling edge with the DUT idle; returns at the falling edge after the done pulse.
  task automatic run_txn(input vec_t v, input string tag);
    int nvalid = 0, wcnt = 0, c;
    bit hs = 0, got = 0, unstable = 0, bus;
    logic [31:0] r_a = 0, r_d = 0;
    logic [3:0]  r_s = 0;
    logic        r_w = 0;
    chk({tag, " ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1; is_store = v.st; f3 = v.f3; addr = v.addr; wdata = v.wdata;
    @(posedge clk); @(negedge clk);
    req_valid = 0; is_store = 1'($urandom); f3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    for (c = 1; c <= 60; c++) begin
      if (done) begin got = 1; break; end
      dr = 0; rv = 0; rrd = $urandom;
      if (hs) begin
        if (wcnt == v.rsp) begin rv = 1; rrd = v.mrd; end
        wcnt++;
      end else if (dv) begin
        if (nvalid == 0) begin r_a = daddr; r_w = dwe; r_s = dwstrb; r_d = dwdata; end
        else if (daddr !== r_a || dwe !== r_w || dwstrb !== r_s || dwdata !== r_d) unstable = 1;
        nvalid++;
        if (nvalid > v.rd) begin dr = 1; hs = 1; end
        else rv = 1'($urandom_range(0, 1));
      end
      @(posedge clk); @(negedge clk);
    end
    bus = (v.e_lat != 1);
    chk({tag, " done_seen"}, 32'(got), 32'd1);
    chk({tag, " latency"}, 32'(c), 32'(v.e_lat));
    chk({tag, " rdata"}, rdata, v.e_rdata);
    chk({tag, " err"}, 32'(err), 32'(v.e_err));
    chk({tag, " misalign"}, 32'(mis), 32'(v.e_mis));
    chk({tag, " ready_in_resp"}, 32'(req_ready), 32'd0);
    chk({tag, " valid_cycles"}, 32'(nvalid), bus ? 32'(v.rd + 1) : 32'd0);
    if (bus) begin
      chk({tag, " dmem_addr"}, r_a, v.addr & 32'hFFFFFFFC);
      chk({tag, " dmem_we"}, 32'(r_w), 32'(v.st));
      chk({tag, " dmem_wstrb"}, 32'(r_s), 32'(v.e_wstrb));
      if (v.st) chk({tag, " dmem_wdata"}, r_d, v.e_wdata);
      chk({tag, " req_stable"}, 32'(unstable), 32'd0);
    end
    dr = 0; rv = 0;
    @(posedge clk); @(negedge clk);
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  vec_t tbl[14];
  vec_t rv_v;

  initial begin
    rst = 1; req_valid = 0; is_store = 0; f3 = 0; addr = 0; wdata = 0; dr = 0; rv = 0; rrd = 0;

    tbl[0]  = mkv(1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0,        32'h0,        0, 0, 4'hF, 32'hDEADBEEF, 3);
    tbl[1]  = mkv(0, 3'd0, 32'h203, 32'h0,        0, 0, 32'h80FF1234, 32'hFFFFFF80, 0, 0, 4'h0, 32'h0, 3);
    tbl[2]  = mkv(0, 3'd4, 32'h203, 32'h0,        0, 0, 32'h80FF1234, 32'h00000080, 0, 0, 4'h0, 32'h0, 3);
    tbl[3]  = mkv(0, 3'd5, 32'h202, 32'h0,        0, 0, 32'h80FF1234, 32'h000080FF, 0, 0, 4'h0, 32'h0, 3);
    tbl[4]  = mkv(1, 3'd1, 32'h302, 32'h0000ABCD, 5, 0, 32'h0,        32'h0,        0, 0, 4'hC, 32'hABCDABCD, 8);
    tbl[5]  = mkv(0, 3'd2, 32'h101, 32'h0,        0, 0, 32'h0,        32'h0,        0, 1, 4'h0, 32'h0, 1);
    tbl[6]  = mkv(0, 3'd3, 32'h100, 32'h0,        0, 0, 32'h0,        32'h0,        1, 0, 4'h0, 32'h0, 1);
    tbl[7]  = mkv(0, 3'd2, 32'h400, 32'h0,        0, 4, 32'h0,        32'h0,        1, 0, 4'h0, 32'h0, 6);
    tbl[8]  = mkv(0, 3'd2, 32'h404, 32'h0,        0, 3, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 4'h0, 32'h0, 6);
    tbl[9]  = mkv(1, 3'd0, 32'h501, 32'h12345677, 0, 0, 32'h0,        32'h0,        0, 0, 4'h2, 32'h77777777, 3);
    tbl[10] = mkv(0, 3'd1, 32'h600, 32'h0,        0, 0, 32'h1234F00D, 32'hFFFFF00D, 0, 0, 4'h0, 32'h0, 3);
    tbl[11] = mkv(1, 3'd4, 32'h600, 32'h11223344, 0, 0, 32'h0,        32'h0,        1, 0, 4'h0, 32'h0, 1);
    tbl[12] = mkv(1, 3'd1, 32'h101, 32'h11223344, 0, 0, 32'h0,        32'h0,        0, 1, 4'h0, 32'h0, 1);
    tbl[13] = mkv(0, 3'd1, 32'h602, 32'h0,        2, 1, 32'h7FFF0000, 32'h00007FFF, 0, 0, 4'h0, 32'h0, 6);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ready", 32'(req_ready), 32'd1);
    chk("reset done", 32'(done), 32'd0);
    chk("reset dmem_valid", 32'(dv), 32'd0);
    chk("reset dmem_addr", daddr, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    rst = 0;

    for (int i = 0; i < 14; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset while a load is waiting on memory, then a stale response must be ignored
    req_valid = 1; is_store = 0; f3 = 3'd2; addr = 32'h700;
    @(posedge clk); @(negedge clk);
    req_valid = 0; dr = 1;
    @(posedge clk); @(negedge clk);
    dr = 0; rst = 1;
    @(posedge clk); @(negedge clk);
    rst = 0;
    chk("rst_wait ready", 32'(req_ready), 32'd1);
    chk("rst_wait done", 32'(done), 32'd0);
    chk("rst_wait dmem_valid", 32'(dv), 32'd0);
    chk("rst_wait err", 32'(err), 32'd0);
    rv = 1; rrd = 32'hA5A5A5A5;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      chk("stale_rsp done", 32'(done), 32'd0);
      chk("stale_rsp ready", 32'(req_ready), 32'd1);
    end
    rv = 0;
    run_txn(tbl[7], "post_rst_timeout");
    run_txn(tbl[0], "post_rst_sw");

    for (int n = 0; n < 200; n++) begin
      rv_v.st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) rv_v.f3 = 3'($urandom_range(0, 7));
      else rv_v.f3 = rv_v.st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 1) ? $urandom_range(0, 2) : $urandom_range(4, 5));
      rv_v.addr = $urandom;
      if ($urandom_range(0, 1) == 1) rv_v.addr[1:0] = 2'b00;
      rv_v.wdata = $urandom;
      rv_v.rd = $urandom_range(0, 3);
      rv_v.rsp = $urandom_range(0, 5);
      rv_v.mrd = $urandom;
      rv_v = model(rv_v);
      run_txn(rv_v, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
